rr_onehot_arbiter: RTL and testbench

Registered round-robin arbiter that shares a single downstream resource between NUM_REQ requesters. Each cycle, a rotating priority mask is applied to the request vector, and the lowest-index set bit is chosen using one-hot priority-encoder logic. The grant is held while the winner keeps requesting, with an optional maximum-hold preemption. It sits in front of shared buses, memory ports or execution units in the libsv coders/arbiters family.

---
 rtl/rr_onehot_arbiter.sv | 135 +++++++++++++
 tb/tb_rr_onehot_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// rr_onehot_arbiter: registered round-robin arbiter with one-hot grant,
// hold-while-requesting and optional maximum-hold preemption.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_onehot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_HOLD  = 0,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_grant_valid,
  output logic [IDX_WIDTH-1:0] o_grant_index
);

  localparam int                 CNT_W      = 16;
  localparam bit                 PREEMPT    = (MAX_HOLD > 0);
  localparam logic [CNT_W-1:0]   HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0]   HOLD_TRIG  = PREEMPT ? CNT_W'(MAX_HOLD - 1) : '0;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0] index_q, index_d;
  logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Requests strictly above the last winner take precedence; otherwise wrap.
  function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_WIDTH-1:0] ptr);
    logic [NUM_REQ-1:0] above;
    logic [NUM_REQ-1:0] src;
    for (int i = 0; i < NUM_REQ; i++) above[i] = (i > int'(ptr));
    src = ((req & above) != '0) ? (req & above) : req;
    return src & (~src + NUM_REQ'(1));
  endfunction

  function automatic logic [IDX_WIDTH-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
    logic [IDX_WIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) if (oh[i]) idx = idx | IDX_WIDTH'(i);
    return idx;
  endfunction

  logic [NUM_REQ-1:0] win_all;
  logic [NUM_REQ-1:0] win_excl;
  logic [NUM_REQ-1:0] new_oh;
  logic               take;
  logic               holder_req;
  logic               others_req;

  always_comb begin
    win_all    = pick(i_req, ptr_q);
    win_excl   = pick(i_req & ~grant_q, ptr_q);
    holder_req = |(i_req & grant_q);
    others_req = |(i_req & ~grant_q);
    new_oh     = '0;
    take       = 1'b0;
    state_d    = state_q;
    grant_d    = grant_q;
    index_d    = index_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          take   = 1'b1;
          new_oh = win_all;
        end
      end
      ST_GRANTED: begin
        if (!holder_req) begin
          if (|i_req) begin
            take   = 1'b1;
            new_oh = win_all;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (PREEMPT && (cnt_q >= HOLD_TRIG) && others_req) begin
          // ">=" lets a saturated sole holder yield as soon as someone arrives.
          take   = 1'b1;
          new_oh = win_excl;
        end else if (cnt_q < HOLD_LIMIT) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase

    if (take) begin
      state_d = ST_GRANTED;
      grant_d = new_oh;
      index_d = oh2idx(new_oh);
      ptr_d   = oh2idx(new_oh);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      index_q <= '0;
      ptr_q   <= IDX_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_valid = (state_q == ST_GRANTED);
  assign o_grant_index = index_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
// ============================================================================
// tb_rr_onehot_arbiter: directed vector table plus preemption, sole-holder
// and randomised invariant sequences for rr_onehot_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rr_onehot_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst4, rst2;
  logic [3:0] req0, req4, req2;
  logic [3:0] g0, g4, g2;
  logic       v0, v4, v2;
  logic [1:0] x0, x4, x2;

  rr_onehot_arbiter #(.NUM_REQ(4), .MAX_HOLD(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst0), .i_req(req0),
    .o_grant(g0), .o_grant_valid(v0), .o_grant_index(x0));

  rr_onehot_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst4), .i_req(req4),
    .o_grant(g4), .o_grant_valid(v4), .o_grant_index(x4));

  rr_onehot_arbiter #(.NUM_REQ(4), .MAX_HOLD(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst2), .i_req(req2),
    .o_grant(g2), .o_grant_valid(v2), .o_grant_index(x2));

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       valid;
    logic [1:0] idx;
  } vec_t;

  localparam int NVEC = 22;
  vec_t vecs[NVEC];

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] g,
                              input logic v, input logic [1:0] i);
    vec_t t;
    t.rst = r; t.req = q; t.grant = g; t.valid = v; t.idx = i;
    return t;
  endfunction

  initial begin
    bit         found;
    logic       ok;
    logic       rnd_rst;
    logic [3:0] rnd_req;

    rst0 = 1'b1; rst4 = 1'b1; rst2 = 1'b1;
    req0 = '0;   req4 = '0;   req2 = '0;

    // MAX_HOLD = 0: reset, handoff, fairness, reset mid-grant, re-grant
    vecs[0]  = mk(1, 4'b1111, 4'b0000, 0, 0);
    vecs[1]  = mk(1, 4'b1111, 4'b0000, 0, 0);
    vecs[2]  = mk(0, 4'b1111, 4'b0001, 1, 0);
    vecs[3]  = mk(0, 4'b0101, 4'b0001, 1, 0);
    vecs[4]  = mk(0, 4'b0100, 4'b0100, 1, 2);
    vecs[5]  = mk(0, 4'b0000, 4'b0000, 0, 2);
    vecs[6]  = mk(0, 4'b0000, 4'b0000, 0, 2);
    vecs[7]  = mk(1, 4'b0000, 4'b0000, 0, 0);
    vecs[8]  = mk(0, 4'b1111, 4'b0001, 1, 0);
    vecs[9]  = mk(0, 4'b1110, 4'b0010, 1, 1);
    vecs[10] = mk(0, 4'b1101, 4'b0100, 1, 2);
    vecs[11] = mk(0, 4'b1011, 4'b1000, 1, 3);
    vecs[12] = mk(0, 4'b0111, 4'b0001, 1, 0);
    vecs[13] = mk(0, 4'b1110, 4'b0010, 1, 1);
    vecs[14] = mk(0, 4'b0100, 4'b0100, 1, 2);
    vecs[15] = mk(1, 4'b1001, 4'b0000, 0, 0);
    vecs[16] = mk(0, 4'b1001, 4'b0001, 1, 0);
    vecs[17] = mk(0, 4'b1001, 4'b0001, 1, 0);
    vecs[18] = mk(0, 4'b1001, 4'b0001, 1, 0);
    vecs[19] = mk(0, 4'b1000, 4'b1000, 1, 3);
    vecs[20] = mk(0, 4'b0000, 4'b0000, 0, 3);
    vecs[21] = mk(0, 4'b1000, 4'b1000, 1, 3);

    for (int i = 0; i < NVEC; i++) begin
      rst0 = vecs[i].rst;
      req0 = vecs[i].req;
      @(posedge clk); #1;
      check($sformatf("vec%0d grant", i), 32'(g0), 32'(vecs[i].grant));
      check($sformatf("vec%0d valid", i), 32'(v0), 32'(vecs[i].valid));
      check($sformatf("vec%0d index", i), 32'(x0), 32'(vecs[i].idx));
    end

    // MAX_HOLD = 4: two constant requesters alternate every 4 cycles
    rst4 = 1'b1; req4 = 4'b0011;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("preempt c%0d", c), 32'(g4),
            32'(((c > 4) && (c <= 8)) ? 4'b0010 : 4'b0001));
    end

    // MAX_HOLD = 2: sole holder keeps grant, yields once another arrives
    rst2 = 1'b1; req2 = 4'b1000;
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("sole c%0d", c), 32'(g2), 32'(4'b1000));
    end
    req2  = 4'b1001;
    found = 1'b0;
    for (int c = 0; c < 2 && !found; c++) begin
      @(posedge clk); #1;
      if (g2 == 4'b0001) found = 1'b1;
    end
    check("sole yield within 2", 32'(found), 32'(1'b1));
    check("sole yield index", 32'(x2), 32'(2'd0));

    // Random stimulus with per-cycle invariants
    for (int n = 0; n < 10000; n++) begin
      rnd_rst = ($urandom_range(0, 99) == 0);
      rnd_req = 4'($urandom_range(0, 15));
      rst4 = rnd_rst;
      req4 = rnd_req;
      @(posedge clk); #1;
      ok = $onehot0(g4) && (v4 == (|g4)) && (!v4 || g4[x4])
           && ((g4 & ~rnd_req) == 4'b0000) && (!rnd_rst || (g4 == 4'b0000));
      check($sformatf("invariant n%0d g=%b req=%b", n, g4, rnd_req), 32'(ok), 32'(1'b1));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
